int_controller: RTL and testbench

- Interrupt source for the multicycle CPU. It drives the control unit's int_sig and consumes the handshake the control unit produces: int_save_pc is the acknowledge, and RFE completion is the end of interrupt.
- Collects rising-edge requests from N peripheral lines, masks them, and selects the highest-priority source (lowest index wins).
- Presents the selected source's handler address on int_vector, which the datapath loads into the PC when pc_source = 3.
- Holds one interrupt in service until end of interrupt arrives. Handlers do not nest.

---
 rtl/cpu_int_pkg.sv | 22 ++
 rtl/int_prio_enc.sv | 23 ++
 rtl/int_controller.sv | 142 ++++++++++++++
 tb/tb_int_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_int_pkg.sv
// Shared definitions between the interrupt controller and the multicycle CPU control unit.
package cpu_int_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } int_state_e;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0080;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // pc_source value that makes the datapath load int_vector into the PC
    localparam logic [1:0] PC_SRC_INT_VECTOR = 2'd3;

    function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                                input logic [31:0] stride,
                                                input logic [31:0] id);
        return base + id * stride;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Priority encoder: index of the lowest set request bit plus a valid flag.
module int_prio_enc #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] req_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    // Scanning downward lets the lowest set index overwrite any higher one
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = ID_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Interrupt source for the multicycle CPU: edge-detects peripheral lines, masks,
// prioritises and holds one non-nesting interrupt in service until RFE.
module int_controller
    import cpu_int_pkg::*;
#(
    parameter int          N_IRQ      = 8,
    parameter int          ID_W       = $clog2(N_IRQ),
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_lines,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             missed_clr,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic             int_sig,
    output logic [31:0]      int_vector,
    output logic [ID_W-1:0]  int_id,
    output logic             in_service,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] missed
);

    int_state_e        state_q, state_d;
    logic [N_IRQ-1:0]  prev_irq_q;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  missed_q, missed_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  rise, cand, ack_clr;
    logic              ack_fire;
    logic              int_sig_q, int_sig_d;
    logic              in_service_q, in_service_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;
    logic [31:0]       int_vector_q, int_vector_d;
    logic [ID_W-1:0]   sel_id;
    logic              sel_valid;

    int_prio_enc #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req_i   (cand),
        .idx_o   (sel_id),
        .valid_o (sel_valid)
    );

    // A new edge on the bit being acknowledged wins over the clear and is not a miss
    always_comb begin
        rise     = irq_lines & ~prev_irq_q;
        cand     = pending_q & mask_q;
        ack_fire = (state_q == REQUEST) && int_ack;
        ack_clr  = '0;
        if (ack_fire) begin
            ack_clr[int_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr) | rise;
        missed_d  = (missed_clr ? '0 : missed_q) | (rise & pending_q & ~ack_clr);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_valid) state_d = REQUEST;
            REQUEST: if (int_ack)   state_d = SERVICE;
            SERVICE: if (int_eoi)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Selection is captured only in IDLE, so it stays committed through REQUEST/SERVICE
    always_comb begin
        int_sig_d    = int_sig_q;
        in_service_d = in_service_q;
        int_id_d     = int_id_q;
        int_vector_d = int_vector_q;
        unique case (state_q)
            IDLE: begin
                int_sig_d    = 1'b0;
                in_service_d = 1'b0;
                if (sel_valid) begin
                    int_sig_d    = 1'b1;
                    int_id_d     = sel_id;
                    int_vector_d = vector_addr(VEC_BASE, VEC_STRIDE, 32'(sel_id));
                end
            end
            REQUEST: begin
                if (int_ack) begin
                    int_sig_d    = 1'b0;
                    in_service_d = 1'b1;
                end
            end
            SERVICE: begin
                if (int_eoi) begin
                    in_service_d = 1'b0;
                end
            end
            default: begin
                int_sig_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_irq_q   <= '0;
            pending_q    <= '0;
            missed_q     <= '0;
            mask_q       <= '0;
            int_sig_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_id_q     <= '0;
            int_vector_q <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            prev_irq_q   <= irq_lines;
            pending_q    <= pending_d;
            missed_q     <= missed_d;
            mask_q       <= mask_d;
            int_sig_q    <= int_sig_d;
            in_service_q <= in_service_d;
            int_id_q     <= int_id_d;
            int_vector_q <= int_vector_d;
        end
    end

    assign int_sig    = int_sig_q;
    assign in_service = in_service_q;
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign pending    = pending_q;
    assign missed     = missed_q;

    // Handlers never nest: a request may not be raised while one is being serviced
    assert property (@(posedge clk) disable iff (rst) !(int_sig_q && in_service_q));

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed plan followed by random traffic,
// both compared every cycle against a rule-level reference model.
module tb_int_controller;

    localparam int          N          = 8;
    localparam logic [31:0] BASE       = 32'h0000_0080;
    localparam logic [31:0] STRIDE     = 32'h0000_0010;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_lines;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         missed_clr;
    logic         int_ack;
    logic         int_eoi;
    logic         int_sig;
    logic [31:0]  int_vector;
    logic [2:0]   int_id;
    logic         in_service;
    logic [N-1:0] pending;
    logic [N-1:0] missed;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = waiting, 1 = asking the CPU, 2 = handler running
    int           mPhase;
    int           mId;
    bit [N-1:0]   mPrev, mPend, mMiss, mMask;

    int_controller #(
        .N_IRQ      (N),
        .ID_W       (3),
        .VEC_BASE   (BASE),
        .VEC_STRIDE (STRIDE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_lines  (irq_lines),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .missed_clr (missed_clr),
        .int_ack    (int_ack),
        .int_eoi    (int_eoi),
        .int_sig    (int_sig),
        .int_vector (int_vector),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [31:0] expVec;
        expVec = BASE + 32'(mId) * STRIDE;
        checkValue("int_sig",    32'(int_sig),    32'(mPhase == 1));
        checkValue("in_service", 32'(in_service), 32'(mPhase == 2));
        checkValue("int_id",     32'(int_id),     32'(mId));
        checkValue("int_vector", int_vector,      expVec);
        checkValue("pending",    32'(pending),    32'(mPend));
        checkValue("missed",     32'(missed),     32'(mMiss));
        checkValue("no_nesting", 32'(int_sig && in_service), 32'd0);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare
    task automatic applyStimulus(input bit r, input bit [N-1:0] irq, input bit mwe,
                                 input bit [N-1:0] mdata, input bit mclr,
                                 input bit ack, input bit eoi);
        bit [N-1:0] rise, newPend, newMiss;
        bit         acked;
        rst        = r;
        irq_lines  = irq;
        mask_we    = mwe;
        mask_wdata = mdata;
        missed_clr = mclr;
        int_ack    = ack;
        int_eoi    = eoi;
        @(posedge clk);
        if (r) begin
            mPrev = '0; mPend = '0; mMiss = '0; mMask = '0;
            mPhase = 0; mId = 0;
        end else begin
            rise    = irq & ~mPrev;
            acked   = (mPhase == 1) && ack;
            newPend = mPend | rise;
            newMiss = mclr ? '0 : mMiss;
            if (acked) newPend[mId] = rise[mId];
            for (int i = 0; i < N; i++) begin
                if (rise[i] && mPend[i] && !(acked && i == mId)) newMiss[i] = 1'b1;
            end
            if (mPhase == 0) begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (mPend[i] && mMask[i]) begin
                        mId    = i;
                        mPhase = 1;
                    end
                end
            end else if (mPhase == 1) begin
                if (ack) mPhase = 2;
            end else begin
                if (eoi) mPhase = 0;
            end
            mPend = newPend;
            mMiss = newMiss;
            mPrev = irq;
            if (mwe) mMask = mdata;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        mPhase = 0; mId = 0; mPrev = '0; mPend = '0; mMiss = '0; mMask = '0;
        rst = 1'b1; irq_lines = '0; mask_we = 1'b0; mask_wdata = '0;
        missed_clr = 1'b0; int_ack = 1'b0; int_eoi = 1'b0;

        // Reset state
        applyStimulus(1, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("reset_vector", int_vector, 32'h80);
        checkValue("reset_sig", 32'(int_sig), 32'd0);

        // Single source, two-cycle latency, acknowledge
        applyStimulus(0, 8'h00, 1, 8'hFF, 0, 0, 0);
        applyStimulus(0, 8'h08, 0, 8'h00, 0, 0, 0);
        checkValue("p1_pending", 32'(pending), 32'h08);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p1_sig", 32'(int_sig), 32'd1);
        checkValue("p1_vector", int_vector, 32'hB0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        checkValue("p1_inserv", 32'(in_service), 32'd1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);

        // Two simultaneous edges: priority and the IDLE gap between handlers
        applyStimulus(0, 8'h24, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p2_first_vec", int_vector, 32'hA0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        checkValue("p2_gap_sig", 32'(int_sig), 32'd0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p2_second_vec", int_vector, 32'hD0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);

        // Masked source stays pending until unmasked
        applyStimulus(0, 8'h00, 1, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h02, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 8'h02, 0, 0, 0);
        checkValue("p3_masked_sig", 32'(int_sig), 32'd0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p3_id", 32'(int_id), 32'd1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);

        // Edge coinciding with ack, then a real miss, then missed_clr
        applyStimulus(0, 8'h00, 1, 8'hFF, 0, 0, 0);
        applyStimulus(0, 8'h10, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h10, 0, 8'h00, 0, 1, 0);
        checkValue("p4_pend_kept", 32'(pending), 32'h10);
        checkValue("p4_no_miss", 32'(missed), 32'h00);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h10, 0, 8'h00, 0, 0, 0);
        checkValue("p4_miss", 32'(missed), 32'h10);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0, 0);
        checkValue("p4_miss_clr", 32'(missed), 32'h00);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);

        // No nesting during service; stray ack/eoi in IDLE
        applyStimulus(0, 8'h02, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h01, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p5_hold_sig", 32'(int_sig), 32'd0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p5_id0", 32'(int_id), 32'd0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 1);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 1);

        // Reset mid-REQUEST and mid-SERVICE
        applyStimulus(0, 8'h08, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h30, 0, 8'h00, 0, 0, 0);
        applyStimulus(1, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p6_req_rst_vec", int_vector, 32'h80);
        applyStimulus(0, 8'h04, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p6_mask_cleared", 32'(int_sig), 32'd0);
        applyStimulus(0, 8'h00, 1, 8'hFF, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1, 0);
        applyStimulus(1, 8'h00, 0, 8'h00, 0, 0, 0);
        checkValue("p6_srv_rst_inserv", 32'(in_service), 32'd0);
        checkValue("p6_srv_rst_pend", 32'(pending), 32'h00);

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          N'($urandom),
                          ($urandom_range(0, 15) == 0),
                          N'($urandom),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
